// File: rtl/demux_16bit_1i_3o.sv
// Write-back distributor: routes one result word into one of three holding registers,
// each with its own valid/ack handshake toward its consumer.
module demux_16bit_1i_3o #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  input  logic             a_ack,
  input  logic             b_ack,
  input  logic             c_ack,
  output logic             sel_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] wr_count
);

  logic [WIDTH-1:0] a_r, b_r, c_r;
  logic             a_valid_r, b_valid_r, c_valid_r;
  logic             sel_err_r;
  logic [CNT_W-1:0] wr_count_r;

  logic ready_s;
  logic accept_s;
  logic wr_a_s, wr_b_s, wr_c_s, wr_bad_s;

  // Destination is free when empty or being drained this cycle; illegal select always sinks.
  always_comb begin
    ready_s = 1'b1;
    case (s)
      2'd0:    ready_s = ~a_valid_r | a_ack;
      2'd1:    ready_s = ~b_valid_r | b_ack;
      2'd2:    ready_s = ~c_valid_r | c_ack;
      2'd3:    ready_s = 1'b1;
      default: ready_s = 1'b1;
    endcase
  end

  // Decode the accepted write into per-destination strobes.
  always_comb begin
    accept_s = in_valid & ready_s;
    wr_a_s   = accept_s & (s == 2'd0);
    wr_b_s   = accept_s & (s == 2'd1);
    wr_c_s   = accept_s & (s == 2'd2);
    wr_bad_s = accept_s & (s == 2'd3);
  end

  // Holding registers and valid flags; a write wins over a same-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      c_r       <= {WIDTH{1'b0}};
      a_valid_r <= 1'b0;
      b_valid_r <= 1'b0;
      c_valid_r <= 1'b0;
    end else begin
      if (wr_a_s) begin
        a_r       <= d;
        a_valid_r <= 1'b1;
      end else if (a_ack) begin
        a_valid_r <= 1'b0;
      end
      if (wr_b_s) begin
        b_r       <= d;
        b_valid_r <= 1'b1;
      end else if (b_ack) begin
        b_valid_r <= 1'b0;
      end
      if (wr_c_s) begin
        c_r       <= d;
        c_valid_r <= 1'b1;
      end else if (c_ack) begin
        c_valid_r <= 1'b0;
      end
    end
  end

  // Sticky illegal-select flag (set beats clear) and legal-write counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_r  <= 1'b0;
      wr_count_r <= {CNT_W{1'b0}};
    end else begin
      if (wr_bad_s) begin
        sel_err_r <= 1'b1;
      end else if (err_clr) begin
        sel_err_r <= 1'b0;
      end
      if (wr_a_s | wr_b_s | wr_c_s) begin
        wr_count_r <= wr_count_r + CNT_W'(1);
      end
    end
  end

  assign in_ready = ready_s;
  assign a        = a_r;
  assign b        = b_r;
  assign c        = c_r;
  assign a_valid  = a_valid_r;
  assign b_valid  = b_valid_r;
  assign c_valid  = c_valid_r;
  assign sel_err  = sel_err_r;
  assign wr_count = wr_count_r;

endmodule

// File: tb/tb_demux_16bit_1i_3o.sv
// Self-checking bench for demux_16bit_1i_3o: directed vector table, reset/wrap sequences,
// and randomized traffic against a behavioural model.
module tb_demux_16bit_1i_3o;

  logic        clk;
  logic        reset_n;
  logic [1:0]  s;
  logic [15:0] d;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b, c;
  logic        a_valid, b_valid, c_valid;
  logic        a_ack, b_ack, c_ack;
  logic        sel_err;
  logic        err_clr;
  logic [7:0]  wr_count;

  int tests_run = 0;
  int tests_failed = 0;

  demux_16bit_1i_3o #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .d(d), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid),
    .a_ack(a_ack), .b_ack(b_ack), .c_ack(c_ack), .sel_err(sel_err), .err_clr(err_clr),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  s;
    logic [15:0] d;
    logic        iv;
    logic [2:0]  ack;   // {c,b,a}
    logic        clr;
    logic        rdy;
    logic [15:0] ea, eb, ec;
    logic [2:0]  ev;    // {c,b,a}
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vt[14];

  // Behavioural model: three slots, a sticky error bit and an integer write tally.
  logic [15:0] m_reg[3];
  bit          m_val[3];
  bit          m_err;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ts, input logic [15:0] td, input logic tiv,
                       input logic [2:0] tack, input logic tclr);
    s = ts; d = td; in_valid = tiv;
    a_ack = tack[0]; b_ack = tack[1]; c_ack = tack[2];
    err_clr = tclr;
  endtask

  function automatic bit m_ready(input logic [1:0] ts, input logic [2:0] tack);
    if (ts == 2'd3) return 1'b1;
    return !m_val[ts] || tack[ts];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_reg[i] = 16'h0000;
      m_val[i] = 1'b0;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic m_step(input logic [1:0] ts, input logic [15:0] td, input logic tiv,
                        input logic [2:0] tack, input logic tclr);
    bit acc;
    acc = tiv && m_ready(ts, tack);
    for (int i = 0; i < 3; i++) begin
      if (acc && ts == i) begin
        m_reg[i] = td;
        m_val[i] = 1'b1;
      end else if (tack[i]) begin
        m_val[i] = 1'b0;
      end
    end
    if (acc && ts == 2'd3) m_err = 1'b1;
    else if (tclr) m_err = 1'b0;
    if (acc && ts != 2'd3) m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_a"}, a, m_reg[0]);
    chk({tag, "_b"}, b, m_reg[1]);
    chk({tag, "_c"}, c, m_reg[2]);
    chk({tag, "_valid"}, {c_valid, b_valid, a_valid}, {m_val[2], m_val[1], m_val[0]});
    chk({tag, "_err"}, sel_err, m_err);
    chk({tag, "_cnt"}, wr_count, m_cnt[7:0]);
  endtask

  initial begin
    //        s     d         iv    ack     clr   rdy   a         b         c         valid   err   cnt
    vt[0]  = '{2'd1, 16'hBEEF, 1'b1, 3'b000, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 16'h0000, 3'b010, 1'b0, 8'd1};
    vt[1]  = '{2'd0, 16'h0000, 1'b0, 3'b010, 1'b0, 1'b1, 16'h0000, 16'hBEEF, 16'h0000, 3'b000, 1'b0, 8'd1};
    vt[2]  = '{2'd0, 16'h1234, 1'b1, 3'b000, 1'b0, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, 3'b001, 1'b0, 8'd2};
    vt[3]  = '{2'd0, 16'h0008, 1'b1, 3'b000, 1'b0, 1'b0, 16'h1234, 16'hBEEF, 16'h0000, 3'b001, 1'b0, 8'd2};
    vt[4]  = '{2'd0, 16'h0008, 1'b1, 3'b000, 1'b0, 1'b0, 16'h1234, 16'hBEEF, 16'h0000, 3'b001, 1'b0, 8'd2};
    vt[5]  = '{2'd0, 16'h0008, 1'b1, 3'b000, 1'b0, 1'b0, 16'h1234, 16'hBEEF, 16'h0000, 3'b001, 1'b0, 8'd2};
    vt[6]  = '{2'd0, 16'h0008, 1'b1, 3'b001, 1'b0, 1'b1, 16'h0008, 16'hBEEF, 16'h0000, 3'b001, 1'b0, 8'd3};
    vt[7]  = '{2'd3, 16'h0010, 1'b1, 3'b000, 1'b0, 1'b1, 16'h0008, 16'hBEEF, 16'h0000, 3'b001, 1'b1, 8'd3};
    vt[8]  = '{2'd0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 16'h0008, 16'hBEEF, 16'h0000, 3'b001, 1'b0, 8'd3};
    vt[9]  = '{2'd3, 16'h0010, 1'b1, 3'b000, 1'b1, 1'b1, 16'h0008, 16'hBEEF, 16'h0000, 3'b001, 1'b1, 8'd3};
    vt[10] = '{2'd2, 16'h00C0, 1'b1, 3'b000, 1'b0, 1'b1, 16'h0008, 16'hBEEF, 16'h00C0, 3'b101, 1'b1, 8'd4};
    vt[11] = '{2'd0, 16'h00A0, 1'b1, 3'b101, 1'b0, 1'b1, 16'h00A0, 16'hBEEF, 16'h00C0, 3'b001, 1'b1, 8'd5};
    vt[12] = '{2'd0, 16'h0000, 1'b0, 3'b010, 1'b0, 1'b0, 16'h00A0, 16'hBEEF, 16'h00C0, 3'b001, 1'b1, 8'd5};
    vt[13] = '{2'd1, 16'h5555, 1'b1, 3'b001, 1'b0, 1'b1, 16'h00A0, 16'h5555, 16'h00C0, 3'b010, 1'b1, 8'd6};

    reset_n = 1'b0;
    drive(2'd0, 16'h0000, 1'b0, 3'b000, 1'b0);
    m_reset();
    #2;
    chk("reset_a", a, 16'h0000);
    chk("reset_valid", {c_valid, b_valid, a_valid}, 3'b000);
    chk("reset_cnt", wr_count, 8'd0);
    chk("reset_err", sel_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].s, vt[i].d, vt[i].iv, vt[i].ack, vt[i].clr);
      #1;
      chk($sformatf("v%0d_ready", i), in_ready, vt[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_a", i), a, vt[i].ea);
      chk($sformatf("v%0d_b", i), b, vt[i].eb);
      chk($sformatf("v%0d_c", i), c, vt[i].ec);
      chk($sformatf("v%0d_valid", i), {c_valid, b_valid, a_valid}, vt[i].ev);
      chk($sformatf("v%0d_err", i), sel_err, vt[i].err);
      chk($sformatf("v%0d_cnt", i), wr_count, vt[i].cnt);
    end

    // Asynchronous reset mid-cycle while a holds valid data.
    drive(2'd0, 16'h1234, 1'b1, 3'b000, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_a", a, 16'h1234);
    chk("pre_rst_av", a_valid, 1'b1);
    drive(2'd1, 16'h7777, 1'b1, 3'b000, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_a", a, 16'h0000);
    chk("async_rst_av", a_valid, 1'b0);
    chk("async_rst_cnt", wr_count, 8'd0);
    chk("async_rst_err", sel_err, 1'b0);
    @(posedge clk); #1;
    chk("rst_hold_b", b, 16'h0000);
    drive(2'd0, 16'h0000, 1'b0, 3'b000, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    m_reset();
    @(posedge clk); #1;

    // 256 back-to-back legal writes with all consumers draining: counter wraps.
    for (int i = 0; i < 256; i++) begin
      drive(2'(i % 3), 16'(i * 8), 1'b1, 3'b111, 1'b0);
      #1;
      if (!in_ready) chk($sformatf("wrap_ready%0d", i), in_ready, 1'b1);
      m_step(2'(i % 3), 16'(i * 8), 1'b1, 3'b111, 1'b0);
      @(posedge clk); #1;
    end
    chk("wrap_cnt", wr_count, 8'd0);
    chk("wrap_a", a, 16'd2040);
    chk("wrap_b", b, 16'd2024);
    chk("wrap_c", c, 16'd2032);
    chk_model("wrap");

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < 400; i++) begin
      logic [1:0]  rs;
      logic [15:0] rd;
      logic        riv, rclr;
      logic [2:0]  rack;
      rs   = 2'($urandom_range(0, 3));
      rd   = 16'($urandom);
      riv  = ($urandom_range(0, 3) != 0);
      rack = 3'($urandom) & 3'($urandom);
      rclr = ($urandom_range(0, 7) == 0);
      drive(rs, rd, riv, rack, rclr);
      #1;
      chk($sformatf("rnd%0d_ready", i), in_ready, m_ready(rs, rack));
      m_step(rs, rd, riv, rack, rclr);
      @(posedge clk); #1;
      chk_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
